// File: rtl/module_iir_biquad_if.sv
// Sample/coefficient bus between the LPF coefficient calculator, the voice
// sample source and the biquad filter. The filter uses the slave modport.
interface module_iir_biquad_if #(
   parameter int unsigned DATA_W   = 18,
   parameter int unsigned NUM_COEF = 5
);
   logic [NUM_COEF*DATA_W-1:0] coefs_flat;
   logic                       coefs_valid;
   logic signed [DATA_W-1:0]   sample_in;
   logic                       sample_in_valid;
   logic                       clear;
   logic signed [DATA_W-1:0]   sample_out;
   logic                       sample_out_rdy;
   logic                       busy;
   logic                       overrun;

   modport master (
      output coefs_flat, coefs_valid, sample_in, sample_in_valid, clear,
      input  sample_out, sample_out_rdy, busy, overrun
   );

   modport slave (
      input  coefs_flat, coefs_valid, sample_in, sample_in_valid, clear,
      output sample_out, sample_out_rdy, busy, overrun
   );
endinterface

// File: rtl/module_iir_biquad.sv
// Biquad IIR filter: y = c2*x0 + c3*x1 + c4*x2 + c0*y1 + c1*y2, computed with a
// single multiplier, one MAC per cycle over five taps, then a rounding step.
// Coefficients arrive as {c0,c1,c2,c3,c4} and are double-buffered so the
// active set only changes between samples.
// Optional feature macro: IIR_BIQUAD_SAT_EN (saturate the result instead of
// wrapping it).
module module_iir_biquad #(
   parameter int unsigned DATA_W    = 18,
   parameter int unsigned ACC_W     = 48,
   parameter int unsigned FRAC_BITS = 16
) (
   input  logic               clk,
   input  logic               reset,
   module_iir_biquad_if.slave bus
);
   localparam int unsigned NUM_COEF = 5;
   localparam int unsigned PROD_W   = 2 * DATA_W;
   localparam int unsigned RES_LO   = FRAC_BITS;
   localparam int unsigned RES_HI   = FRAC_BITS + DATA_W - 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      MAC0  = 3'd1,
      MAC1  = 3'd2,
      MAC2  = 3'd3,
      MAC3  = 3'd4,
      MAC4  = 3'd5,
      ROUND = 3'd6
   } state_t;

   state_t state_q, state_d;

   logic signed [DATA_W-1:0]   coef_q [NUM_COEF];
   logic [NUM_COEF*DATA_W-1:0] shadow_q;
   logic                       pending_q;
   logic                       clear_req_q;
   logic signed [DATA_W-1:0]   x0_q, x1_q, x2_q, y1_q, y2_q;
   logic signed [ACC_W-1:0]    acc_q;
   logic signed [DATA_W-1:0]   sample_out_q;
   logic                       sample_out_rdy_q;
   logic                       busy_q;
   logic                       overrun_q;

   logic                       accept_c;
   logic                       drop_c;
   logic                       load_coef_c;
   logic                       clr_hist_c;
   logic                       mac_en_c;
   logic                       mac_first_c;
   logic                       round_c;
   logic signed [DATA_W-1:0]   mul_a_c, mul_b_c;
   logic signed [PROD_W-1:0]   prod_c;
   logic signed [ACC_W-1:0]    prod_ext_c;
   logic signed [ACC_W-1:0]    acc_sum_c;
   logic signed [DATA_W-1:0]   result_c;
   logic                       unused_acc_c;

   assign bus.sample_out     = sample_out_q;
   assign bus.sample_out_rdy = sample_out_rdy_q;
   assign bus.busy           = busy_q;
   assign bus.overrun        = overrun_q;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state, tap selection and datapath strobes
   always_comb begin
      state_d     = state_q;
      accept_c    = 1'b0;
      drop_c      = 1'b0;
      load_coef_c = 1'b0;
      clr_hist_c  = 1'b0;
      mac_en_c    = 1'b0;
      mac_first_c = 1'b0;
      round_c     = 1'b0;
      mul_a_c     = '0;
      mul_b_c     = '0;
      if (state_q != IDLE) drop_c = bus.sample_in_valid;
      unique case (state_q)
         IDLE: begin
            if (bus.clear) begin
               clr_hist_c = 1'b1;
               drop_c     = bus.sample_in_valid;
            end else if (bus.sample_in_valid) begin
               accept_c = 1'b1;
               state_d  = MAC0;
            end
            load_coef_c = pending_q && !accept_c;
         end
         MAC0: begin
            mac_en_c    = 1'b1;
            mac_first_c = 1'b1;
            mul_a_c     = coef_q[2];
            mul_b_c     = x0_q;
            state_d     = MAC1;
         end
         MAC1: begin
            mac_en_c = 1'b1;
            mul_a_c  = coef_q[3];
            mul_b_c  = x1_q;
            state_d  = MAC2;
         end
         MAC2: begin
            mac_en_c = 1'b1;
            mul_a_c  = coef_q[4];
            mul_b_c  = x2_q;
            state_d  = MAC3;
         end
         MAC3: begin
            mac_en_c = 1'b1;
            mul_a_c  = coef_q[0];
            mul_b_c  = y1_q;
            state_d  = MAC4;
         end
         MAC4: begin
            mac_en_c = 1'b1;
            mul_a_c  = coef_q[1];
            mul_b_c  = y2_q;
            state_d  = ROUND;
         end
         ROUND: begin
            round_c    = 1'b1;
            clr_hist_c = bus.clear || clear_req_q;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Single shared multiplier, sign-extended into the accumulator
   assign prod_c     = PROD_W'(mul_a_c) * PROD_W'(mul_b_c);
   assign prod_ext_c = ACC_W'(prod_c);
   assign acc_sum_c  = acc_q + prod_ext_c;

   // Only the result window (and its guard bits when saturating) is consumed
   assign unused_acc_c = ^{acc_q[ACC_W-1:RES_HI+1], acc_q[RES_LO-1:0]};

`ifdef IIR_BIQUAD_SAT_EN
   logic [ACC_W-RES_HI-1:0] acc_hi_c;
   assign acc_hi_c = acc_q[ACC_W-1:RES_HI];

   // Clamp when the bits above the result window are not a pure sign extension
   always_comb begin
      result_c = acc_q[RES_HI:RES_LO];
      if (!((&acc_hi_c) || (~|acc_hi_c))) begin
         if (acc_q[ACC_W-1]) result_c = {1'b1, {(DATA_W-1){1'b0}}};
         else                result_c = {1'b0, {(DATA_W-1){1'b1}}};
      end
   end
`else
   // Plain truncation of the Q1.16 window (two's-complement wrap)
   assign result_c = acc_q[RES_HI:RES_LO];
`endif

   // Datapath: sample/history registers, accumulator and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x0_q             <= '0;
         x1_q             <= '0;
         x2_q             <= '0;
         y1_q             <= '0;
         y2_q             <= '0;
         acc_q            <= '0;
         sample_out_q     <= '0;
         sample_out_rdy_q <= 1'b0;
         busy_q           <= 1'b0;
         overrun_q        <= 1'b0;
         clear_req_q      <= 1'b0;
      end else begin
         sample_out_rdy_q <= round_c;
         overrun_q        <= drop_c;
         busy_q           <= (state_d != IDLE);
         if (accept_c) x0_q <= bus.sample_in;
         if (mac_en_c) acc_q <= mac_first_c ? prod_ext_c : acc_sum_c;
         if (round_c) sample_out_q <= result_c;
         if (clr_hist_c) begin
            x1_q <= '0;
            x2_q <= '0;
            y1_q <= '0;
            y2_q <= '0;
         end else if (round_c) begin
            x2_q <= x1_q;
            x1_q <= x0_q;
            y2_q <= y1_q;
            y1_q <= result_c;
         end
         if (round_c)                               clear_req_q <= 1'b0;
         else if (bus.clear && (state_q != IDLE))   clear_req_q <= 1'b1;
      end
   end

   // Coefficient double buffer: shadow captures, active loads only between samples
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shadow_q  <= '0;
         pending_q <= 1'b0;
         for (int unsigned i = 0; i < NUM_COEF; i++) coef_q[i] <= '0;
      end else begin
         if (bus.coefs_valid) shadow_q <= bus.coefs_flat;
         if (bus.coefs_valid)  pending_q <= 1'b1;
         else if (load_coef_c) pending_q <= 1'b0;
         if (load_coef_c) begin
            for (int unsigned i = 0; i < NUM_COEF; i++)
               coef_q[i] <= shadow_q[(NUM_COEF-1-i)*DATA_W +: DATA_W];
         end
      end
   end
endmodule

// File: tb/tb_module_iir_biquad.sv
// Directed bench for module_iir_biquad with hand-computed Q1.16 results.
`timescale 1ns/1ps
module tb_module_iir_biquad;
   localparam int unsigned DW = 18;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   module_iir_biquad_if #(.DATA_W(DW)) bus ();

   module_iir_biquad #(.DATA_W(DW), .ACC_W(48), .FRAC_BITS(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_coefs(input logic [17:0] c0, c1, c2, c3, c4);
      bus.coefs_flat  = {c0, c1, c2, c3, c4};
      bus.coefs_valid = 1'b1;
      step();
      bus.coefs_valid = 1'b0;
      step();
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
   endtask

   // Drive one sample through the accept edge; returns busy just after it
   task automatic start_sample(input logic [17:0] x, output logic b);
      bus.sample_in       = x;
      bus.sample_in_valid = 1'b1;
      step();
      bus.sample_in_valid = 1'b0;
      b = bus.busy;
   endtask

   // Wait (bounded) for sample_out_rdy; lat counts edges after the accept edge
   task automatic wait_rdy(input int done, output logic [17:0] y, output int lat,
                           output logic b);
      logic seen;
      seen = 1'b0;
      lat  = done;
      while (!seen && lat < 30) begin
         step();
         lat++;
         seen = bus.sample_out_rdy;
      end
      if (!seen) lat = -1;
      y = bus.sample_out;
      b = bus.busy;
   endtask

   task automatic run_sample(input logic [17:0] x, output logic [17:0] y, output int lat);
      logic b;
      start_sample(x, b);
      wait_rdy(0, y, lat, b);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2 reset = 1'b0;
      step();
      n_tests++; if (bus.sample_out !== 18'h0) begin n_fail++; $display("FAIL reset_sample_out: got %h expected 0", bus.sample_out); end
      n_tests++; if (bus.sample_out_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b expected 0", bus.sample_out_rdy); end
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
      reset = 1'b1;
      step();
   endtask

   task automatic test_passthrough();
      logic [17:0] y;
      int lat;
      logic b_acc, b_rdy;
      load_coefs(18'h0, 18'h0, 18'h10000, 18'h0, 18'h0);
      start_sample(18'h08000, b_acc);
      n_tests++; if (b_acc !== 1'b1) begin n_fail++; $display("FAIL pass_busy_after_accept: got %b expected 1", b_acc); end
      wait_rdy(0, y, lat, b_rdy);
      n_tests++; if (lat !== 6) begin n_fail++; $display("FAIL pass_latency: got %0d expected 6", lat); end
      n_tests++; if (y !== 18'h08000) begin n_fail++; $display("FAIL pass_y: got %h expected 08000", y); end
      n_tests++; if (b_rdy !== 1'b0) begin n_fail++; $display("FAIL pass_busy_at_rdy: got %b expected 0", b_rdy); end
      step();
      n_tests++; if (bus.sample_out_rdy !== 1'b0) begin n_fail++; $display("FAIL pass_rdy_pulse: got %b expected 0", bus.sample_out_rdy); end
      n_tests++; if (bus.sample_out !== 18'h08000) begin n_fail++; $display("FAIL pass_hold: got %h expected 08000", bus.sample_out); end
   endtask

   task automatic test_recursion();
      logic [17:0] y;
      int lat;
      do_clear();
      load_coefs(18'h08000, 18'h0, 18'h10000, 18'h0, 18'h0);
      run_sample(18'h10000, y, lat);
      n_tests++; if (y !== 18'h10000) begin n_fail++; $display("FAIL rec_y0: got %h expected 10000", y); end
      step();
      run_sample(18'h0, y, lat);
      n_tests++; if (y !== 18'h08000) begin n_fail++; $display("FAIL rec_y1: got %h expected 08000", y); end
      step();
      run_sample(18'h0, y, lat);
      n_tests++; if (y !== 18'h04000) begin n_fail++; $display("FAIL rec_y2: got %h expected 04000", y); end
      // -0.5 * 0.5 = -0.25
      do_clear();
      load_coefs(18'h0, 18'h0, 18'h38000, 18'h0, 18'h0);
      run_sample(18'h08000, y, lat);
      n_tests++; if (y !== 18'h3C000) begin n_fail++; $display("FAIL rec_negative: got %h expected 3c000", y); end
   endtask

   task automatic test_saturation();
      logic [17:0] y, exp_y;
      int lat;
`ifdef IIR_BIQUAD_SAT_EN
      exp_y = 18'h1FFFF;
`else
      exp_y = 18'h2FFFD;
`endif
      do_clear();
      load_coefs(18'h0, 18'h0, 18'h10000, 18'h10000, 18'h10000);
      run_sample(18'h0FFFF, y, lat);
      n_tests++; if (y !== 18'h0FFFF) begin n_fail++; $display("FAIL sat_y0: got %h expected 0ffff", y); end
      run_sample(18'h0FFFF, y, lat);
      n_tests++; if (y !== 18'h1FFFE) begin n_fail++; $display("FAIL sat_y1: got %h expected 1fffe", y); end
      run_sample(18'h0FFFF, y, lat);
      n_tests++; if (y !== exp_y) begin n_fail++; $display("FAIL sat_y2: got %h expected %h", y, exp_y); end
   endtask

   task automatic test_overrun();
      logic [17:0] y;
      int lat;
      logic b;
      do_clear();
      load_coefs(18'h0, 18'h0, 18'h10000, 18'h10000, 18'h0);
      start_sample(18'h01000, b);
      step();
      step();
      bus.sample_in       = 18'h07000;
      bus.sample_in_valid = 1'b1;
      step();
      bus.sample_in_valid = 1'b0;
      n_tests++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse: got %b expected 1", bus.overrun); end
      step();
      n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_pulse_end: got %b expected 0", bus.overrun); end
      wait_rdy(4, y, lat, b);
      n_tests++; if (lat !== 6) begin n_fail++; $display("FAIL ovr_latency: got %0d expected 6", lat); end
      n_tests++; if (y !== 18'h01000) begin n_fail++; $display("FAIL ovr_y: got %h expected 01000", y); end
      // Back-to-back accept in the rdy cycle; x1 must be 0x1000, not 0x7000
      run_sample(18'h02000, y, lat);
      n_tests++; if (y !== 18'h03000) begin n_fail++; $display("FAIL ovr_history: got %h expected 03000", y); end
   endtask

   task automatic test_coef_timing();
      logic [17:0] y;
      int lat;
      logic b;
      do_clear();
      load_coefs(18'h0, 18'h0, 18'h10000, 18'h0, 18'h0);
      bus.sample_in       = 18'h08000;
      bus.sample_in_valid = 1'b1;
      bus.coefs_flat      = {18'h0, 18'h0, 18'h08000, 18'h0, 18'h0};
      bus.coefs_valid     = 1'b1;
      step();
      bus.sample_in_valid = 1'b0;
      bus.coefs_valid     = 1'b0;
      wait_rdy(0, y, lat, b);
      n_tests++; if (y !== 18'h08000) begin n_fail++; $display("FAIL coef_same_cycle_old: got %h expected 08000", y); end
      step();
      run_sample(18'h08000, y, lat);
      n_tests++; if (y !== 18'h04000) begin n_fail++; $display("FAIL coef_same_cycle_new: got %h expected 04000", y); end
      step();
      start_sample(18'h08000, b);
      step();
      bus.coefs_flat  = {18'h0, 18'h0, 18'h18000, 18'h0, 18'h0};
      bus.coefs_valid = 1'b1;
      step();
      bus.coefs_valid = 1'b0;
      wait_rdy(2, y, lat, b);
      n_tests++; if (y !== 18'h04000) begin n_fail++; $display("FAIL coef_mid_old: got %h expected 04000", y); end
      step();
      run_sample(18'h08000, y, lat);
      n_tests++; if (y !== 18'h0C000) begin n_fail++; $display("FAIL coef_mid_new: got %h expected 0c000", y); end
   endtask

   task automatic test_clear();
      logic [17:0] y;
      int lat;
      logic b;
      do_clear();
      load_coefs(18'h0, 18'h0, 18'h10000, 18'h10000, 18'h10000);
      run_sample(18'h01000, y, lat);
      run_sample(18'h01000, y, lat);
      n_tests++; if (y !== 18'h02000) begin n_fail++; $display("FAIL clr_accum: got %h expected 02000", y); end
      do_clear();
      run_sample(18'h01000, y, lat);
      n_tests++; if (y !== 18'h01000) begin n_fail++; $display("FAIL clr_idle: got %h expected 01000", y); end
      // clear and sample together: clear wins, sample dropped
      bus.clear           = 1'b1;
      bus.sample_in       = 18'h05000;
      bus.sample_in_valid = 1'b1;
      step();
      bus.clear           = 1'b0;
      bus.sample_in_valid = 1'b0;
      n_tests++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL clr_drop_overrun: got %b expected 1", bus.overrun); end
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL clr_drop_busy: got %b expected 0", bus.busy); end
      run_sample(18'h01000, y, lat);
      n_tests++; if (y !== 18'h01000) begin n_fail++; $display("FAIL clr_drop_history: got %h expected 01000", y); end
      // clear while busy: current result keeps history, next sample starts fresh
      start_sample(18'h01000, b);
      step();
      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
      wait_rdy(2, y, lat, b);
      n_tests++; if (y !== 18'h02000) begin n_fail++; $display("FAIL clr_busy_current: got %h expected 02000", y); end
      run_sample(18'h01000, y, lat);
      n_tests++; if (y !== 18'h01000) begin n_fail++; $display("FAIL clr_busy_next: got %h expected 01000", y); end
   endtask

   task automatic test_reset_mid();
      logic [17:0] y;
      int lat;
      logic b;
      logic rdy_seen;
      do_clear();
      load_coefs(18'h08000, 18'h0, 18'h10000, 18'h10000, 18'h10000);
      run_sample(18'h01000, y, lat);
      run_sample(18'h01000, y, lat);
      n_tests++; if (y !== 18'h02800) begin n_fail++; $display("FAIL rstmid_pre: got %h expected 02800", y); end
      start_sample(18'h01000, b);
      step();
      step();
      step();
      reset = 1'b0;
      #1;
      n_tests++; if (bus.sample_out !== 18'h0) begin n_fail++; $display("FAIL rstmid_out: got %h expected 0", bus.sample_out); end
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
      n_tests++; if (bus.sample_out_rdy !== 1'b0) begin n_fail++; $display("FAIL rstmid_rdy: got %b expected 0", bus.sample_out_rdy); end
      step();
      step();
      reset = 1'b1;
      rdy_seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus.sample_out_rdy) rdy_seen = 1'b1;
      end
      n_tests++; if (rdy_seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_rdy: got %b expected 0", rdy_seen); end
      load_coefs(18'h08000, 18'h0, 18'h10000, 18'h10000, 18'h10000);
      run_sample(18'h01000, y, lat);
      n_tests++; if (lat !== 6) begin n_fail++; $display("FAIL rstmid_latency: got %0d expected 6", lat); end
      n_tests++; if (y !== 18'h01000) begin n_fail++; $display("FAIL rstmid_first: got %h expected 01000", y); end
   endtask

   initial begin
      bus.coefs_flat      = '0;
      bus.coefs_valid     = 1'b0;
      bus.sample_in       = '0;
      bus.sample_in_valid = 1'b0;
      bus.clear           = 1'b0;
      test_reset();
      test_passthrough();
      test_recursion();
      test_saturation();
      test_overrun();
      test_coef_timing();
      test_clear();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end
endmodule
